// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit is resolved per cycle in RUN. Divide-by-zero and signed
// overflow are resolved at accept time and go straight to DONE. All outputs
// are registered from the next-state values, so done/result never depend
// combinationally on the inputs.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      div_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  // Two's complement negation at operand width.
  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    negate = ~x + XLEN'(1);
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [XLEN-1:0]   rem_r, rem_s;
  logic [XLEN-1:0]   quo_r, quo_s;
  logic [XLEN-1:0]   dvs_r, dvs_s;
  logic [2:0]        op_r, op_s;
  logic              neg_q_r, neg_q_s;
  logic              neg_r_r, neg_r_s;
  logic [4:0]        rd_r, rd_s;
  logic [XLEN-1:0]   result_s;
  logic [4:0]        rd_out_s;

  logic              sign_a_s, sign_b_s;
  logic [XLEN:0]     shifted_s;
  logic              ge_s;
  logic [XLEN:0]     diff_s;
  logic [XLEN-1:0]   rem_step_s, quo_step_s;

  // Next-state, datapath iteration and output staging.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    rem_s      = rem_r;
    quo_s      = quo_r;
    dvs_s      = dvs_r;
    op_s       = op_r;
    neg_q_s    = neg_q_r;
    neg_r_s    = neg_r_r;
    rd_s       = rd_r;
    result_s   = result;
    rd_out_s   = rd_out;

    sign_a_s   = ~div_op[0] & dividend[XLEN-1];
    sign_b_s   = ~div_op[0] & divisor[XLEN-1];

    // One restoring step: the XLEN+1-bit compare keeps unsigned operands
    // with the MSB set from overflowing.
    shifted_s  = {rem_r, quo_r[XLEN-1]};
    diff_s     = shifted_s - {1'b0, dvs_r};
    ge_s       = (shifted_s >= {1'b0, dvs_r});
    rem_step_s = ge_s ? diff_s[XLEN-1:0] : shifted_s[XLEN-1:0];
    quo_step_s = {quo_r[XLEN-2:0], ge_s};

    case (state_r)
      IDLE: begin
        if (flush) begin
          state_s = IDLE;
        end else if (start && div_op[2]) begin
          op_s    = div_op;
          rd_s    = rd_in;
          neg_q_s = sign_a_s ^ sign_b_s;
          neg_r_s = sign_a_s;
          dvs_s   = sign_b_s ? negate(divisor) : divisor;
          if (divisor == '0) begin
            result_s = div_op[1] ? dividend : ALL_ONES;
            rd_out_s = rd_in;
            state_s  = DONE;
          end else if (!div_op[0] && (dividend == INT_MIN) && (divisor == ALL_ONES)) begin
            result_s = div_op[1] ? '0 : INT_MIN;
            rd_out_s = rd_in;
            state_s  = DONE;
          end else begin
            rem_s   = '0;
            quo_s   = sign_a_s ? negate(dividend) : dividend;
            cnt_s   = '0;
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_s = IDLE;
        end else begin
          rem_s = rem_step_s;
          quo_s = quo_step_s;
          cnt_s = cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            state_s  = DONE;
            rd_out_s = rd_r;
            if (op_r[1]) begin
              result_s = neg_r_r ? negate(rem_step_s) : rem_step_s;
            end else begin
              result_s = neg_q_r ? negate(quo_step_s) : quo_step_s;
            end
          end else begin
            state_s = RUN;
          end
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      rem_r   <= '0;
      quo_r   <= '0;
      dvs_r   <= '0;
      op_r    <= 3'b000;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      rd_r    <= 5'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rd_out  <= 5'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      rem_r   <= rem_s;
      quo_r   <= quo_s;
      dvs_r   <= dvs_s;
      op_r    <= op_s;
      neg_q_r <= neg_q_s;
      neg_r_r <= neg_r_s;
      rd_r    <= rd_s;
      busy    <= (state_s != IDLE);
      done    <= (state_s == DONE);
      result  <= result_s;
      rd_out  <= rd_out_s;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit with a result scoreboard.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_res = 32'd0;
  logic [4:0]  last_rd = 5'd0;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .div_op(div_op),
    .dividend(dividend), .divisor(divisor), .rd_in(rd_in), .flush(flush),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for done (bounded), compare against the scoreboard.
  // pulse_at > 0 drives a spurious start in that cycle after accept.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat, input int pulse_at);
    exp_t e;
    int   cycles;
    int   busy_cnt;
    div_op = op; dividend = a; divisor = b; rd_in = rd; start = 1'b1;
    e.res = exp_res; e.rd = rd; e.lat = exp_lat;
    sb.push_back(e);
    tick();
    start = 1'b0;
    cycles = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && cycles < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (cycles == pulse_at) begin
        start = 1'b1; div_op = OP_DIV; dividend = 32'hDEAD_BEEF; divisor = 32'd1; rd_in = 5'd31;
      end else begin
        start = 1'b0;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    if (busy === 1'b1) busy_cnt++;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    e = sb.pop_front();
    check({tag, "_result"}, result, e.res);
    check({tag, "_rd"}, {27'd0, rd_out}, {27'd0, e.rd});
    check({tag, "_latency"}, 32'(cycles), 32'(e.lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_held"}, result, e.res);
    last_res = e.res;
    last_rd = e.rd;
  endtask

  initial begin
    logic seen_done;
    rst = 1'b1; start = 1'b0; div_op = 3'b000; dividend = 32'd0; divisor = 32'd0;
    rd_in = 5'd0; flush = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd", {27'd0, rd_out}, 32'd0);

    // Main function
    run_op("div_100_7",   OP_DIV,  32'd100,      32'd7,        5'd5,  32'd14,       33, 0);
    run_op("rem_m100_7",  OP_REM,  32'hFFFFFF9C, 32'd7,        5'd6,  32'hFFFFFFFE, 33, 0);
    run_op("div_m100_7",  OP_DIV,  32'hFFFFFF9C, 32'd7,        5'd7,  32'hFFFFFFF2, 33, 0);
    run_op("div_100_m7",  OP_DIV,  32'd100,      32'hFFFFFFF9, 5'd8,  32'hFFFFFFF2, 33, 0);
    run_op("rem_100_m7",  OP_REM,  32'd100,      32'hFFFFFFF9, 5'd9,  32'd2,        33, 0);
    run_op("divu_big",    OP_DIVU, 32'hFFFFFFFF, 32'h10,       5'd10, 32'h0FFFFFFF, 33, 0);
    run_op("remu_big",    OP_REMU, 32'hFFFFFFFF, 32'h10,       5'd11, 32'hF,        33, 0);
    run_op("divu_msb",    OP_DIVU, 32'hF0000000, 32'hE0000000, 5'd12, 32'd1,        33, 0);
    run_op("remu_msb",    OP_REMU, 32'hF0000000, 32'hE0000000, 5'd13, 32'h10000000, 33, 0);

    // Special cases
    run_op("div_by_zero", OP_DIV,  32'h1234,     32'd0,        5'd14, 32'hFFFFFFFF, 1, 0);
    run_op("rem_by_zero", OP_REM,  32'h1234,     32'd0,        5'd15, 32'h1234,     1, 0);
    run_op("div_ovf",     OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1, 0);
    run_op("rem_ovf",     OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        1, 0);

    // Spurious start during RUN is ignored
    run_op("start_in_run", OP_DIVU, 32'd1000,    32'd10,       5'd3,  32'd100,      33, 5);

    // Flush at T+10
    div_op = OP_DIV; dividend = 32'd1000; divisor = 32'd3; rd_in = 5'd20; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result_held", result, last_res);
    check("flush_rd_held", {27'd0, rd_out}, {27'd0, last_rd});
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen_done = 1'b1;
      tick();
    end
    check("flush_no_done", {31'd0, seen_done}, 32'd0);

    // Flush has priority over start in IDLE
    div_op = OP_DIV; dividend = 32'd50; divisor = 32'd5; rd_in = 5'd21; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_prio_busy", {31'd0, busy}, 32'd0);

    // Reset at T+20
    div_op = OP_DIVU; dividend = 32'd77; divisor = 32'd7; rd_in = 5'd22; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_rd", {27'd0, rd_out}, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen_done = 1'b1;
      tick();
    end
    check("rst_no_done", {31'd0, seen_done}, 32'd0);

    // Non-divide op is not accepted
    div_op = 3'b000; dividend = 32'd9; divisor = 32'd3; rd_in = 5'd23; start = 1'b1;
    tick();
    start = 1'b0;
    check("op000_busy", {31'd0, busy}, 32'd0);
    tick();
    check("op000_busy_later", {31'd0, busy}, 32'd0);
    check("op000_done", {31'd0, done}, 32'd0);

    // Recovery after reset
    run_op("after_rst", OP_REMU, 32'd77, 32'd7, 5'd24, 32'd0, 33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
